uart_rx_frame_decoder: RTL and testbench
========================================

# uart_rx_frame_decoder

Synthesizable 8N1 UART receiver with a small output FIFO. It sits directly downstream of the processor's `uart0_txd_o` line. It turns the serial stream into a valid/ready byte stream for on-chip consumers and for the simulation string checkers, and reports framing errors and overflow.

## Interface

Parameters:
- `CLOCK_FREQ`, default 100000000: core clock frequency in Hz.
- `BAUD_RATE`, default 19200: serial bit rate.
- `FIFO_DEPTH`, default 4: number of byte entries. Must be a power of 2 and ≥ 2.

Ports:
- `clk_i`, in, 1: clock. All logic is on the rising edge.
- `rst_i`, in, 1: reset. Synchronous, active-high.
- `txd_i`, in, 1: serial line. Asynchronous to `clk_i`; idle level is 1.
- `data_o`, out, 8: byte at the FIFO head.
- `valid_o`, out, 1: FIFO not empty.
- `ready_i`, in, 1: consumer accepts `data_o`.
- `frame_err_o`, out, 1: one-cycle pulse when a received stop bit is 0.
- `overflow_o`, out, 1: sticky flag. Set when a byte is dropped because the FIFO is full.

## Operation

Derived constants:
- `BAUD_DIV = CLOCK_FREQ / BAUD_RATE`, integer truncation. This is 5208 at the defaults.
- `HALF = BAUD_DIV / 2`, truncated. This is 2604 at the defaults.
- The bit-timing counter is `$clog2(BAUD_DIV+1)` bits wide.

Input path:
- `txd_i` passes through a 2-flop synchronizer. Both flops reset to 1.
- A third register holds the previous synchronized value, for falling-edge detection.

State machine:
- `ARM`
  - Entered on reset and after a framing error.
  - Counts consecutive cycles with the synchronized line at 1. Any 0 clears the count.
  - When the count reaches `BAUD_DIV`, go to `IDLE`.
- `IDLE`
  - On a synchronized falling edge (current 0, previous 1), clear the counter and go to `START`.
- `START`
  - After `HALF` cycles, sample the line.
  - Sample 0: go to `DATA` with the bit index at 0.
  - Sample 1: treat as a glitch and go to `IDLE`. No error is flagged.
- `DATA`
  - Sample every `BAUD_DIV` cycles.
  - Shift bits in LSB first. After bit 7, go to `STOP`.
- `STOP`
  - Sample after `BAUD_DIV` cycles.
  - Sample 1: push the byte into the FIFO and go to `IDLE`.
  - Sample 0: discard the byte, pulse `frame_err_o` for 1 cycle, and go to `ARM`. This handles break conditions without retriggering.

FIFO:
- `valid_o` is 1 whenever the FIFO is not empty. `data_o` is the head entry and is stable while `valid_o && !ready_i`.
- A pop occurs when `valid_o && ready_i`.
- Push when full and no pop in the same cycle: the new byte is dropped and `overflow_o` is set.
- Push and pop in the same cycle while full: both take effect, the occupancy is unchanged, and there is no overflow.
- Push and pop in the same cycle while empty is impossible, because `valid_o` is 0 when empty.
- Read and write pointers wrap modulo `FIFO_DEPTH`. Full and empty are distinguished by an extra pointer bit.

## Timing

Reset values:
- `data_o` = 0, `valid_o` = 0, `frame_err_o` = 0, `overflow_o` = 0.
- FIFO empty, state `ARM`, synchronizer flops = 1.
- A reset in mid-frame aborts the frame and discards the partial byte. The receiver then needs `BAUD_DIV` idle cycles before it accepts a new start bit.

Frame timing, where E0 is the first rising edge that samples `txd_i` = 0:
- E0+2: the FSM is in `START` with the counter cleared.
- E0+2+HALF: start-bit sample.
- E0+2+HALF+(n+1)·BAUD_DIV: sample of data bit n, for n = 0..7.
- E0+2+HALF+9·BAUD_DIV: stop-bit sample.
- Next edge: `valid_o` = 1 if the FIFO was empty, or `frame_err_o` = 1 for exactly 1 cycle.

Other timing:
- Pop latency: after a pop, the next entry appears on `data_o` on the following edge.
- Back-to-back frames are accepted. The FSM is back in `IDLE` one cycle after the stop sample, which is mid-stop-bit.

## Test plan

- **Reset state:** hold `rst_i` = 1 for 10 cycles with `txd_i` = 1 → all outputs are 0. After release and `BAUD_DIV` idle cycles, the FSM is in `IDLE`.
- **Single byte:** send 0x4E ("N") at the defaults with `ready_i` = 1 → `valid_o` rises at E0+2+2604+9·5208+1, with `data_o` = 0x4E. `valid_o` is high for exactly 1 cycle.
- **String and buffering:** send "NEORV32" back-to-back with `ready_i` = 0 and `FIFO_DEPTH` = 4 → "NEOR" is buffered and "V32" is dropped, and `overflow_o` = 1 and stays 1. With `ready_i` = 1, all 7 bytes are seen in order and `overflow_o` = 0.
- **Framing error:** send 0x55 with stop bit = 0 → `frame_err_o` is 1 for 1 cycle and no push occurs. A following 0xA5, sent after ≥ 1 idle bit time, is received correctly.
- **Glitch rejection:** drive a 0 pulse of 1000 cycles on an idle line → no byte, no error, and the FSM returns to `IDLE`.
- **Boundary cases:**
  - Full FIFO with a push and pop in the same cycle → no overflow and the byte order is preserved.
  - `rst_i` asserted during data bit 4 → no output byte. A clean frame sent afterwards is received correctly.

Source files
------------

// File: rtl/uart_rx_frame_decoder.sv
// uart_rx_frame_decoder: 8N1 UART receiver feeding a small valid/ready byte FIFO
module uart_rx_frame_decoder #(
  parameter int CLOCK_FREQ = 100000000,
  parameter int BAUD_RATE  = 19200,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       txd_i,
  output logic [7:0] data_o,
  output logic       valid_o,
  input  logic       ready_i,
  output logic       frame_err_o,
  output logic       overflow_o
);
  localparam int BAUD_DIV = CLOCK_FREQ / BAUD_RATE;
  localparam int HALF = BAUD_DIV / 2;
  localparam int CW = $clog2(BAUD_DIV + 1);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] DIV_M1 = CW'(BAUD_DIV - 1);
  localparam logic [CW-1:0] HALF_M1 = CW'(HALF - 1);
  typedef enum logic [2:0] {ARM, IDLE, START, DATA, STOP} state_t;
  state_t state_q, state_d;
  logic sync1_q, sync2_q, prev_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] shift_q, shift_d;
  logic push_q, push_d, ferr_q, ferr_d, frame_err_q, ovf_q;
  logic [7:0] mem_q [FIFO_DEPTH];
  logic [AW:0] wptr_q, rptr_q;
  logic empty, full, pop, wr;
  // Two-flop synchronizer plus a history flop for falling-edge detection
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      sync1_q <= txd_i;
      sync2_q <= sync1_q;
      prev_q <= sync2_q;
    end
  end
  // Receiver state, bit timing and the one-cycle push/error strobes
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ARM;
      cnt_q <= '0;
      bit_q <= '0;
      shift_q <= '0;
      push_q <= 1'b0;
      ferr_q <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      bit_q <= bit_d;
      shift_q <= shift_d;
      push_q <= push_d;
      ferr_q <= ferr_d;
      frame_err_q <= ferr_q;
    end
  end
  // Next-state logic; a 0 stop bit falls back to ARM so a held break cannot retrigger
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q + CW'(1);
    bit_d = bit_q;
    shift_d = shift_q;
    push_d = 1'b0;
    ferr_d = 1'b0;
    case (state_q)
      ARM: begin
        cnt_d = sync2_q ? cnt_q + CW'(1) : '0;
        if (sync2_q && cnt_q == DIV_M1) begin
          state_d = IDLE;
          cnt_d = '0;
        end
      end
      IDLE: begin
        cnt_d = '0;
        if (!sync2_q && prev_q) state_d = START;
      end
      START: if (cnt_q == HALF_M1) begin
        cnt_d = '0;
        bit_d = '0;
        state_d = sync2_q ? IDLE : DATA;
      end
      DATA: if (cnt_q == DIV_M1) begin
        cnt_d = '0;
        shift_d = {sync2_q, shift_q[7:1]};
        bit_d = bit_q + 3'd1;
        if (bit_q == 3'd7) state_d = STOP;
      end
      STOP: if (cnt_q == DIV_M1) begin
        cnt_d = '0;
        state_d = sync2_q ? IDLE : ARM;
        push_d = sync2_q;
        ferr_d = !sync2_q;
      end
      default: state_d = ARM;
    endcase
  end
  assign empty = wptr_q == rptr_q;
  assign full = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign pop = valid_o && ready_i;
  assign wr = push_q && (!full || pop);
  // Output FIFO; extra pointer bit separates full from empty
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      ovf_q <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (wr) mem_q[wptr_q[AW-1:0]] <= shift_q;
      wptr_q <= wptr_q + {{AW{1'b0}}, wr};
      rptr_q <= rptr_q + {{AW{1'b0}}, pop};
      if (push_q && full && !pop) ovf_q <= 1'b1;
    end
  end
  assign data_o = mem_q[rptr_q[AW-1:0]];
  assign valid_o = !empty;
  assign frame_err_o = frame_err_q;
  assign overflow_o = ovf_q;
endmodule

// File: tb/tb_uart_rx_frame_decoder.sv
// tb_uart_rx_frame_decoder: directed frames with a scoreboard-checked byte/error stream
module tb_uart_rx_frame_decoder;
  localparam int BD = 17;
  localparam int LAT = 164;
  localparam int ERR = 256;
  logic clk = 1'b0, rst_i = 1'b1, txd_i = 1'b1, ready_i = 1'b1;
  logic [7:0] data_o;
  logic valid_o, frame_err_o, overflow_o;
  int vectors = 0, miss = 0, cyc = 0, e0 = 0, rise_cyc = -1, fall_cyc = -1;
  int q[$];
  logic vprev = 1'b0, ferr_prev = 1'b0;
  uart_rx_frame_decoder #(.CLOCK_FREQ(1700), .BAUD_RATE(100), .FIFO_DEPTH(4)) dut (
    .clk_i(clk), .rst_i(rst_i), .txd_i(txd_i), .data_o(data_o), .valid_o(valid_o),
    .ready_i(ready_i), .frame_err_o(frame_err_o), .overflow_o(overflow_o)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string nm, input int act, input int req);
    vectors++;
    if (act != req) begin
      miss++;
      $display("FAIL %s: got %0d expected %0d", nm, act, req);
    end
  endtask
  always @(negedge clk) begin
    if (!rst_i) begin
      if (valid_o && !vprev) rise_cyc = cyc;
      if (!valid_o && vprev) fall_cyc = cyc;
      if (valid_o && ready_i) begin
        if (q.size() == 0) chk("unexpected_byte", int'(data_o), -1);
        else chk("byte", int'(data_o), q.pop_front());
      end
      if (frame_err_o) begin
        if (q.size() == 0) chk("unexpected_frame_err", 1, 0);
        else chk("frame_err", ERR, q.pop_front());
        if (ferr_prev) chk("frame_err_width", 2, 1);
      end
    end
    vprev = valid_o;
    ferr_prev = frame_err_o;
  end
  task automatic send(input logic [7:0] b, input logic stop);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    @(posedge clk); #1;
    e0 = cyc + 1;
    for (int i = 0; i < 10; i++) begin
      txd_i = f[i];
      repeat (BD) @(posedge clk);
      #1;
    end
    txd_i = 1'b1;
  endtask
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic drain(input string nm);
    for (int i = 0; i < 3000 && q.size() != 0; i++) @(posedge clk);
    chk(nm, q.size(), 0);
  endtask
  task automatic do_reset(input int n);
    rst_i = 1'b1;
    idle(n);
    rst_i = 1'b0;
  endtask
  initial begin
    logic [7:0] s [7];
    int t;
    s = '{8'h4E, 8'h45, 8'h4F, 8'h52, 8'h56, 8'h33, 8'h32};
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("rst_data", int'(data_o), 0);
    chk("rst_valid", int'(valid_o), 0);
    chk("rst_frame_err", int'(frame_err_o), 0);
    chk("rst_overflow", int'(overflow_o), 0);
    #1 rst_i = 1'b0;
    idle(BD + 2);
    q.push_back(8'h4E);
    send(8'h4E, 1'b1);
    idle(3);
    chk("valid_latency", rise_cyc - e0, LAT);
    chk("valid_width", fall_cyc - rise_cyc, 1);
    foreach (s[i]) q.push_back(int'(s[i]));
    foreach (s[i]) send(s[i], 1'b1);
    drain("string_drain");
    chk("string_no_overflow", int'(overflow_o), 0);
    q.push_back(ERR);
    send(8'h55, 1'b0);
    idle(3 * BD);
    q.push_back(8'hA5);
    send(8'hA5, 1'b1);
    drain("ferr_drain");
    txd_i = 1'b0;
    idle(4);
    txd_i = 1'b1;
    idle(3 * BD);
    q.push_back(8'h3C);
    send(8'h3C, 1'b1);
    drain("glitch_drain");
    ready_i = 1'b0;
    for (int i = 0; i < 4; i++) q.push_back(int'(s[i]));
    foreach (s[i]) send(s[i], 1'b1);
    idle(2 * BD);
    chk("overflow_set", int'(overflow_o), 1);
    idle(4 * BD);
    chk("overflow_sticky", int'(overflow_o), 1);
    ready_i = 1'b1;
    drain("buffer_drain");
    chk("overflow_after_drain", int'(overflow_o), 1);
    do_reset(3);
    chk("overflow_cleared", int'(overflow_o), 0);
    idle(BD + 2);
    ready_i = 1'b0;
    q.push_back(8'h11); q.push_back(8'h22); q.push_back(8'h33); q.push_back(8'h44); q.push_back(8'h5A);
    send(8'h11, 1'b1);
    send(8'h22, 1'b1);
    send(8'h33, 1'b1);
    send(8'h44, 1'b1);
    fork
      send(8'h5A, 1'b1);
      begin
        @(posedge clk); #1;
        t = cyc + LAT - 1;
        for (int i = 0; i < 1000 && cyc != t; i++) begin
          @(posedge clk); #1;
        end
        ready_i = 1'b1;
        @(posedge clk); #1;
        ready_i = 1'b0;
      end
    join
    idle(BD);
    chk("full_pushpop_no_overflow", int'(overflow_o), 0);
    chk("full_pushpop_valid", int'(valid_o), 1);
    ready_i = 1'b1;
    drain("full_pushpop_drain");
    fork
      send(8'hC3, 1'b1);
      begin
        @(posedge clk); #1;
        t = cyc + 90;
        for (int i = 0; i < 1000 && cyc != t; i++) begin
          @(posedge clk); #1;
        end
        do_reset(3);
      end
    join
    idle(3 * BD);
    chk("midframe_no_byte", int'(valid_o), 0);
    q.push_back(8'h6B);
    send(8'h6B, 1'b1);
    drain("midframe_recover");
    idle(BD);
    chk("final_no_overflow", int'(overflow_o), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miss);
    $finish;
  end
endmodule
